// File: rtl/ram_sched_pkg.sv
// Shared constants and types for the nibble-serial RAM port scheduler.
package ram_sched_pkg;

  localparam int unsigned RAM_PINS        = 4;
  localparam int unsigned RAM_LOG2_CYCLES = 2;
  localparam int unsigned ADDR_BITS       = 16;
  localparam int unsigned TRANS_DELAY     = 2;

  // Upper bound on requester-id width carried through the in-flight pipe.
  localparam int unsigned ID_MAX_W        = 8;

  // One in-flight slot: whether a word is outstanding and who asked for it.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } inflight_t;

  // Requester-id width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_sched_arbiter.sv
// Grant logic for the RAM port scheduler.
// Macro RAM_SCHED_RR_EN: round-robin with a last-grant pointer register;
// undefined: fixed priority, lowest index wins, no state.
module ram_sched_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
`ifdef RAM_SCHED_RR_EN
  input  logic               clk,
  input  logic               rst_n,
`endif
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic               i_strobe,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [NUM_REQ-1:0] w_pick;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_found;

`ifdef RAM_SCHED_RR_EN
  logic [ID_W-1:0] r_ptr;

  // Pick the first asserting requester after the last granted one.
  // Split into two ascending passes (above pointer, then wrap) instead of a modulo walk.
  always_comb begin
    int unsigned p;
    p         = 32'(r_ptr);
    w_pick    = '0;
    w_pick_id = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i > p) && i_req_valid[i]) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_pick_id = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && (i <= p) && i_req_valid[i]) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_pick_id = ID_W'(i);
      end
    end
  end

  // Pointer follows the last transfer; resets so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= ID_W'(NUM_REQ - 1);
    end else if (|o_grant) begin
      r_ptr <= w_pick_id;
    end
  end
`else
  // Fixed priority: lowest asserting index wins.
  always_comb begin
    w_pick    = '0;
    w_pick_id = '0;
    w_found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_found && i_req_valid[i]) begin
        w_found   = 1'b1;
        w_pick[i] = 1'b1;
        w_pick_id = ID_W'(i);
      end
    end
  end
`endif

  // Grants exist only on the arbitration cycle of each slot.
  always_comb begin
    o_grant    = i_strobe ? w_pick : '0;
    o_grant_id = w_pick_id;
  end

endmodule

// File: rtl/ram_port_scheduler.sv
// Arbiter and slot sequencer for the shared nibble-serial RAM port.
// Issues one granted address per slot, LS nibble first, and assembles the
// word returning TRANS_DELAY slots later into a tagged one-cycle response.
// Macro RAM_SCHED_RR_EN selects round-robin arbitration (default: fixed priority).
module ram_port_scheduler #(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned RAM_PINS        = ram_sched_pkg::RAM_PINS,
  parameter int unsigned RAM_LOG2_CYCLES = ram_sched_pkg::RAM_LOG2_CYCLES,
  parameter int unsigned ADDR_BITS       = ram_sched_pkg::ADDR_BITS,
  parameter int unsigned TRANS_DELAY     = ram_sched_pkg::TRANS_DELAY
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]                 req_addr,
  output logic [NUM_REQ-1:0]                           req_ready,
  output logic [RAM_PINS-1:0]                          addr_bits,
  input  logic [RAM_PINS-1:0]                          data_bits,
  output logic                                         rsp_valid,
  output logic [ram_sched_pkg::id_width(NUM_REQ)-1:0]  rsp_id,
  output logic [ADDR_BITS-1:0]                         rsp_data,
  output logic                                         idle
);

  import ram_sched_pkg::*;

  localparam int unsigned RAM_CYCLES = 1 << RAM_LOG2_CYCLES;
  localparam int unsigned ID_W       = id_width(NUM_REQ);

  logic [RAM_LOG2_CYCLES-1:0]    r_sub;
  logic                          w_strobe;
  logic [NUM_REQ-1:0]            w_grant;
  logic [ID_W-1:0]               w_grant_id;
  logic                          w_xfer;
  logic [ADDR_BITS-1:0]          w_sel_addr;

  logic [ADDR_BITS-1:0]          r_addr;
  logic [ID_W-1:0]               r_id;
  logic                          r_issue;

  inflight_t                     r_flight [TRANS_DELAY];
  inflight_t                     w_head;
  logic                          w_any_flight;

  logic [ADDR_BITS-RAM_PINS-1:0] r_asm;
  logic [ADDR_BITS-1:0]          w_word;

  logic                          r_rsp_valid;
  logic [ID_W-1:0]               r_rsp_id;
  logic [ADDR_BITS-1:0]          r_rsp_data;
  logic                          r_idle;

  assign w_strobe = (r_sub == '1);
  assign w_xfer   = |w_grant;
  assign w_head   = r_flight[TRANS_DELAY-1];

  ram_sched_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
`ifdef RAM_SCHED_RR_EN
    .clk         (clk),
    .rst_n       (rst_n),
`endif
    .i_req_valid (req_valid),
    .i_strobe    (w_strobe),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id)
  );

  // Address of the winning requester.
  always_comb begin
    w_sel_addr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) w_sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
    end
  end

  // Free-running slot phase counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sub <= '0;
    else        r_sub <= r_sub + 1'b1;
  end

  // Latch the granted request; the following slot issues it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_issue <= 1'b0;
    end else if (w_strobe) begin
      r_issue <= w_xfer;
      if (w_xfer) begin
        r_addr <= w_sel_addr;
        r_id   <= w_grant_id;
      end
    end
  end

  // Serialise the address one nibble per cycle of an issue slot.
  always_comb begin
    addr_bits = '0;
    if (r_issue) begin
      for (int unsigned k = 0; k < RAM_CYCLES; k++) begin
        if (r_sub == RAM_LOG2_CYCLES'(k)) addr_bits = r_addr[k*RAM_PINS +: RAM_PINS];
      end
    end
  end

  // In-flight pipe: entry enters when its issue slot ends, head marks the return slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TRANS_DELAY; i++) r_flight[i] <= '0;
    end else if (w_strobe) begin
      r_flight[0] <= '{valid: r_issue, id: ID_MAX_W'(r_id)};
      for (int unsigned i = 1; i < TRANS_DELAY; i++) r_flight[i] <= r_flight[i-1];
    end
  end

  // Any word outstanding in the pipe.
  always_comb begin
    w_any_flight = 1'b0;
    for (int unsigned i = 0; i < TRANS_DELAY; i++) w_any_flight = w_any_flight | r_flight[i].valid;
  end

  // Collect the lower data nibbles of a return slot; the top nibble is taken live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_asm <= '0;
    end else if (w_head.valid) begin
      for (int unsigned k = 0; k < RAM_CYCLES - 1; k++) begin
        if (r_sub == RAM_LOG2_CYCLES'(k)) r_asm[k*RAM_PINS +: RAM_PINS] <= data_bits;
      end
    end
  end

  assign w_word = {data_bits, r_asm};

  // Register the completed word at the end of the return slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_strobe & w_head.valid;
      if (w_strobe && w_head.valid) begin
        r_rsp_id   <= ID_W'(w_head.id);
        r_rsp_data <= w_word;
      end
    end
  end

  // Idle once nothing is issuing and nothing is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_idle <= 1'b1;
    else        r_idle <= ~(r_issue | w_any_flight);
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign idle      = r_idle;

endmodule
